// File: rtl/mem_arbiter.sv
// Two-to-one arbiter that shares one memory port between instruction fetch and data access.
// Grants are combinational. Read returns are steered back through an in-order FIFO of source tags.
module mem_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int MAX_STREAK      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] imem_addr,
    input  logic        imem_rd,
    output logic        imem_wait,
    output logic [31:0] imem_rddata,
    output logic        imem_rvalid,
    input  logic [29:0] dmem_addr,
    input  logic        dmem_rd,
    input  logic        dmem_wr,
    input  logic [31:0] dmem_wrdata,
    input  logic [3:0]  dmem_wrmask,
    output logic        dmem_wait,
    output logic [31:0] dmem_rddata,
    output logic        dmem_rvalid,
    output logic [29:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wrdata,
    output logic [3:0]  mem_wrmask,
    input  logic        mem_wait,
    input  logic [31:0] mem_rddata,
    input  logic        mem_rvalid,
    output logic        err
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic                       lock_q;
    logic                       lock_src_q;
    logic [3:0]                 streak_q;
    logic [MAX_OUTSTANDING-1:0] tag_q;
    logic [PW-1:0]              wr_ptr_q;
    logic [PW-1:0]              rd_ptr_q;
    logic [CW-1:0]              count_q;
    logic                       err_q;

    logic sel_valid;
    logic sel_dmem;
    logic sel_rd;
    logic sel_wr;
    logic block;
    logic accept;
    logic push;
    logic pop;
    logic streak_max;
    logic fifo_full;
    logic fifo_empty;

    assign streak_max = (streak_q == 4'(MAX_STREAK));
    assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);

    // A stalled request keeps the port until memory takes it, so the lock outranks priority.
    always_comb begin
        sel_valid = 1'b0;
        sel_dmem  = 1'b0;
        if (lock_q) begin
            sel_dmem  = lock_src_q;
            sel_valid = lock_src_q ? (dmem_rd | dmem_wr) : imem_rd;
        end else if (imem_rd && streak_max) begin
            sel_valid = 1'b1;
        end else if (dmem_rd || dmem_wr) begin
            sel_valid = 1'b1;
            sel_dmem  = 1'b1;
        end else if (imem_rd) begin
            sel_valid = 1'b1;
        end
    end

    assign sel_rd = sel_valid & (sel_dmem ? dmem_rd : imem_rd);
    assign sel_wr = sel_valid & sel_dmem & dmem_wr;
    assign block  = sel_rd & fifo_full;
    assign accept = (sel_rd | sel_wr) & ~mem_wait & ~block;
    assign push   = accept & sel_rd;
    assign pop    = mem_rvalid & ~fifo_empty;

    always_comb begin
        mem_rd     = sel_rd & ~block;
        mem_wr     = sel_wr;
        mem_addr   = '0;
        mem_wrdata = '0;
        mem_wrmask = '0;
        if (sel_valid) begin
            if (sel_dmem) begin
                mem_addr   = dmem_addr;
                mem_wrdata = dmem_wrdata;
                mem_wrmask = dmem_wrmask;
            end else begin
                mem_addr = imem_addr;
            end
        end
        imem_wait = (sel_valid && !sel_dmem) ? ~accept : imem_rd;
        dmem_wait = (sel_valid && sel_dmem) ? ~accept : (dmem_rd | dmem_wr);
    end

    assign imem_rddata = mem_rddata;
    assign dmem_rddata = mem_rddata;
    assign imem_rvalid = pop & ~tag_q[rd_ptr_q];
    assign dmem_rvalid = pop & tag_q[rd_ptr_q];
    assign err         = err_q;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q     <= 1'b0;
            lock_src_q <= 1'b0;
            streak_q   <= '0;
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if ((mem_rd || mem_wr) && mem_wait) begin
                lock_q     <= 1'b1;
                lock_src_q <= sel_dmem;
            end else if (accept) begin
                lock_q <= 1'b0;
            end

            if ((accept && !sel_dmem) || !imem_rd) begin
                streak_q <= '0;
            end else if (accept && sel_dmem && !streak_max) begin
                streak_q <= streak_q + 1'b1;
            end

            if (push) begin
                tag_q[wr_ptr_q] <= sel_dmem;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end

            if (mem_rvalid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle tables for the listed scenarios, then random traffic
// compared against a queue-based reference of the arbitration rules.
module tb_mem_arbiter;

    localparam int MAX_OUT = 4;
    localparam int MAX_STR = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] imem_addr;
    logic        imem_rd;
    logic        imem_wait;
    logic [31:0] imem_rddata;
    logic        imem_rvalid;
    logic [29:0] dmem_addr;
    logic        dmem_rd;
    logic        dmem_wr;
    logic [31:0] dmem_wrdata;
    logic [3:0]  dmem_wrmask;
    logic        dmem_wait;
    logic [31:0] dmem_rddata;
    logic        dmem_rvalid;
    logic [29:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wrdata;
    logic [3:0]  mem_wrmask;
    logic        mem_wait;
    logic [31:0] mem_rddata;
    logic        mem_rvalid;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;

    mem_arbiter #(.MAX_OUTSTANDING(MAX_OUT), .MAX_STREAK(MAX_STR)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_wait(imem_wait),
        .imem_rddata(imem_rddata), .imem_rvalid(imem_rvalid),
        .dmem_addr(dmem_addr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .dmem_wrdata(dmem_wrdata), .dmem_wrmask(dmem_wrmask), .dmem_wait(dmem_wait),
        .dmem_rddata(dmem_rddata), .dmem_rvalid(dmem_rvalid),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wrdata(mem_wrdata), .mem_wrmask(mem_wrmask), .mem_wait(mem_wait),
        .mem_rddata(mem_rddata), .mem_rvalid(mem_rvalid), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        i_rd;
        logic [29:0] i_addr;
        logic        d_rd;
        logic        d_wr;
        logic [29:0] d_addr;
        logic        m_wait;
        logic        m_rvalid;
        logic [31:0] m_rdata;
        logic        e_iwait;
        logic        e_dwait;
        logic        e_mrd;
        logic        e_mwr;
        logic [29:0] e_maddr;
        logic        e_irv;
        logic        e_drv;
        logic        e_err;
    } vec_t;

    vec_t rows[$];

    function automatic vec_t mk(logic i_rd, logic [29:0] i_addr, logic d_rd, logic d_wr,
                                logic [29:0] d_addr, logic m_wait, logic m_rvalid,
                                logic [31:0] m_rdata, logic e_iwait, logic e_dwait,
                                logic e_mrd, logic e_mwr, logic [29:0] e_maddr,
                                logic e_irv, logic e_drv, logic e_err);
        vec_t r;
        r = '{i_rd, i_addr, d_rd, d_wr, d_addr, m_wait, m_rvalid, m_rdata,
              e_iwait, e_dwait, e_mrd, e_mwr, e_maddr, e_irv, e_drv, e_err};
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        imem_rd     = 1'b0;
        imem_addr   = '0;
        dmem_rd     = 1'b0;
        dmem_wr     = 1'b0;
        dmem_addr   = '0;
        dmem_wrdata = '0;
        dmem_wrmask = '0;
        mem_wait    = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rddata  = '0;
    endtask

    // Inputs change on the falling edge and outputs are sampled 1 ns later, well before the next rising edge.
    task automatic applyStimulus(input vec_t r, input string name);
        @(negedge clk);
        imem_rd     = r.i_rd;
        imem_addr   = r.i_addr;
        dmem_rd     = r.d_rd;
        dmem_wr     = r.d_wr;
        dmem_addr   = r.d_addr;
        dmem_wrdata = {2'b00, r.d_addr};
        dmem_wrmask = 4'hF;
        mem_wait    = r.m_wait;
        mem_rvalid  = r.m_rvalid;
        mem_rddata  = r.m_rdata;
        #1;
        checkOutput({name, ".imem_wait"},   imem_wait,   r.e_iwait);
        checkOutput({name, ".dmem_wait"},   dmem_wait,   r.e_dwait);
        checkOutput({name, ".mem_rd"},      mem_rd,      r.e_mrd);
        checkOutput({name, ".mem_wr"},      mem_wr,      r.e_mwr);
        checkOutput({name, ".mem_addr"},    mem_addr,    r.e_maddr);
        checkOutput({name, ".imem_rvalid"}, imem_rvalid, r.e_irv);
        checkOutput({name, ".dmem_rvalid"}, dmem_rvalid, r.e_drv);
        checkOutput({name, ".err"},         err,         r.e_err);
        if (r.m_rvalid) begin
            checkOutput({name, ".imem_rddata"}, imem_rddata, r.m_rdata);
            checkOutput({name, ".dmem_rddata"}, dmem_rddata, r.m_rdata);
        end
    endtask

    task automatic run_rows(input string tag);
        for (int i = 0; i < rows.size(); i++) begin
            applyStimulus(rows[i], $sformatf("%s[%0d]", tag, i));
        end
        rows.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Reference state: outstanding read owners in issue order, fetch-starvation count, stalled owner.
    bit m_tags[$];
    int m_streak;
    int m_locked_to;
    bit m_err;

    task automatic run_random(input int cycles);
        bit i_pend = 0;
        bit d_pend = 0;
        bit d_is_wr = 0;
        int who;
        bit is_rd, full, taken, ret, ret_dmem;
        logic exp_mrd, exp_mwr, exp_iw, exp_dw;
        logic [29:0] exp_addr;
        string nm;
        m_tags.delete();
        m_streak    = 0;
        m_locked_to = 0;
        m_err       = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (!i_pend && $urandom_range(1, 0) == 1) begin
                i_pend    = 1;
                imem_addr = 30'($urandom);
            end
            if (!d_pend && $urandom_range(1, 0) == 1) begin
                d_pend      = 1;
                d_is_wr     = 1'($urandom_range(1, 0));
                dmem_addr   = 30'($urandom);
                dmem_wrdata = $urandom;
                dmem_wrmask = 4'($urandom);
            end
            imem_rd    = i_pend;
            dmem_rd    = d_pend & ~d_is_wr;
            dmem_wr    = d_pend & d_is_wr;
            mem_wait   = ($urandom_range(9, 0) < 3);
            mem_rvalid = (m_tags.size() != 0) && ($urandom_range(9, 0) < 4);
            mem_rddata = $urandom;
            #1;

            // who: 0 nobody, 1 fetch, 2 data
            if (m_locked_to != 0)                   who = m_locked_to;
            else if (i_pend && m_streak == MAX_STR) who = 1;
            else if (d_pend)                        who = 2;
            else if (i_pend)                        who = 1;
            else                                    who = 0;
            is_rd    = (who == 1) || (who == 2 && !d_is_wr);
            full     = is_rd && (m_tags.size() == MAX_OUT);
            exp_mrd  = is_rd && !full;
            exp_mwr  = (who == 2) && d_is_wr;
            taken    = (who != 0) && !mem_wait && !full;
            exp_iw   = (who == 1) ? !taken : i_pend;
            exp_dw   = (who == 2) ? !taken : d_pend;
            exp_addr = (who == 1) ? imem_addr : (who == 2) ? dmem_addr : 30'd0;
            ret      = mem_rvalid && (m_tags.size() != 0);
            ret_dmem = ret ? m_tags[0] : 1'b0;

            nm = $sformatf("rand[%0d]", c);
            checkOutput({nm, ".imem_wait"},   imem_wait,   exp_iw);
            checkOutput({nm, ".dmem_wait"},   dmem_wait,   exp_dw);
            checkOutput({nm, ".mem_rd"},      mem_rd,      exp_mrd);
            checkOutput({nm, ".mem_wr"},      mem_wr,      exp_mwr);
            checkOutput({nm, ".mem_addr"},    mem_addr,    exp_addr);
            if (exp_mwr) begin
                checkOutput({nm, ".mem_wrdata"}, mem_wrdata, dmem_wrdata);
                checkOutput({nm, ".mem_wrmask"}, mem_wrmask, dmem_wrmask);
            end
            checkOutput({nm, ".imem_rvalid"}, imem_rvalid, ret && !ret_dmem);
            checkOutput({nm, ".dmem_rvalid"}, dmem_rvalid, ret && ret_dmem);
            checkOutput({nm, ".rddata"},      imem_rddata, mem_rddata);
            checkOutput({nm, ".err"},         err,         m_err);

            if (ret) void'(m_tags.pop_front());
            if (taken && is_rd) m_tags.push_back(who == 2);
            if ((exp_mrd || exp_mwr) && mem_wait) m_locked_to = who;
            else if (taken)                       m_locked_to = 0;
            if ((who == 1 && taken) || !i_pend)   m_streak = 0;
            else if (who == 2 && taken)           m_streak = (m_streak < MAX_STR) ? m_streak + 1 : MAX_STR;
            if (who == 1 && taken) i_pend = 0;
            if (who == 2 && taken) d_pend = 0;
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        mem_rvalid = 1'b1;
        #3;
        checkOutput("reset.err",         err,         1'b0);
        checkOutput("reset.imem_rvalid", imem_rvalid, 1'b0);
        checkOutput("reset.dmem_rvalid", dmem_rvalid, 1'b0);
        checkOutput("reset.mem_rd",      mem_rd,      1'b0);
        mem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Single fetch with return, the D,D,D,I grant rotation, then interleaved read returns.
        rows.push_back(mk(0, 0,      0, 0, 0,      0, 0, 0,            0, 0, 0, 0, 0,      0, 0, 0));
        rows.push_back(mk(1, 'h100,  0, 0, 0,      0, 0, 0,            0, 0, 1, 0, 'h100,  0, 0, 0));
        rows.push_back(mk(0, 0,      0, 0, 0,      0, 0, 0,            0, 0, 0, 0, 0,      0, 0, 0));
        rows.push_back(mk(0, 0,      0, 0, 0,      0, 1, 'hDEADBEEF,   0, 0, 0, 0, 0,      1, 0, 0));
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++)
                rows.push_back(mk(1, 30'('h104 + 4 * k), 0, 1, 'h40, 0, 0, 0, 1, 0, 0, 1, 'h40, 0, 0, 0));
            rows.push_back(mk(1, 30'('h104 + 4 * k), 0, 1, 'h40, 0, 0, 0, 0, 1, 1, 0, 30'('h104 + 4 * k), 0, 0, 0));
        end
        rows.push_back(mk(0, 0,      0, 0, 0,      0, 1, 5,            0, 0, 0, 0, 0,      1, 0, 0));
        rows.push_back(mk(0, 0,      0, 0, 0,      0, 1, 6,            0, 0, 0, 0, 0,      1, 0, 0));
        rows.push_back(mk(1, 'h200,  0, 0, 0,      0, 0, 0,            0, 0, 1, 0, 'h200,  0, 0, 0));
        rows.push_back(mk(0, 0,      1, 0, 'h80,   0, 0, 0,            0, 0, 1, 0, 'h80,   0, 0, 0));
        rows.push_back(mk(1, 'h204,  0, 0, 0,      0, 0, 0,            0, 0, 1, 0, 'h204,  0, 0, 0));
        rows.push_back(mk(0, 0,      0, 0, 0,      0, 1, 1,            0, 0, 0, 0, 0,      1, 0, 0));
        rows.push_back(mk(0, 0,      0, 0, 0,      0, 1, 2,            0, 0, 0, 0, 0,      0, 1, 0));
        rows.push_back(mk(0, 0,      0, 0, 0,      0, 1, 3,            0, 0, 0, 0, 0,      1, 0, 0));
        rows.push_back(mk(0, 0,      0, 0, 0,      0, 0, 0,            0, 0, 0, 0, 0,      0, 0, 0));
        run_rows("table");

        // Data read stalled three cycles holds the port against a newly arrived fetch.
        rows.push_back(mk(0, 0,      1, 0, 'h20,   1, 0, 0,            0, 1, 1, 0, 'h20,   0, 0, 0));
        rows.push_back(mk(1, 'h300,  1, 0, 'h20,   1, 0, 0,            1, 1, 1, 0, 'h20,   0, 0, 0));
        rows.push_back(mk(1, 'h300,  1, 0, 'h20,   1, 0, 0,            1, 1, 1, 0, 'h20,   0, 0, 0));
        rows.push_back(mk(1, 'h300,  1, 0, 'h20,   0, 0, 0,            1, 0, 1, 0, 'h20,   0, 0, 0));
        rows.push_back(mk(1, 'h300,  0, 0, 0,      0, 0, 0,            0, 0, 1, 0, 'h300,  0, 0, 0));
        rows.push_back(mk(0, 0,      0, 0, 0,      0, 1, 'hA6,         0, 0, 0, 0, 0,      0, 1, 0));
        rows.push_back(mk(0, 0,      0, 0, 0,      0, 1, 'hA7,         0, 0, 0, 0, 0,      1, 0, 0));
        // Stalled fetch keeps the port even though a data write (normally higher priority) arrives.
        rows.push_back(mk(1, 'h400,  0, 0, 0,      1, 0, 0,            1, 0, 1, 0, 'h400,  0, 0, 0));
        rows.push_back(mk(1, 'h400,  0, 1, 'h50,   1, 0, 0,            1, 1, 1, 0, 'h400,  0, 0, 0));
        rows.push_back(mk(1, 'h400,  0, 1, 'h50,   0, 0, 0,            0, 1, 1, 0, 'h400,  0, 0, 0));
        rows.push_back(mk(0, 0,      0, 1, 'h50,   0, 0, 0,            0, 0, 0, 1, 'h50,   0, 0, 0));
        rows.push_back(mk(0, 0,      0, 0, 0,      0, 1, 'hB5,         0, 0, 0, 0, 0,      1, 0, 0));
        run_rows("lock");

        // Fill the tag FIFO, check blocking, write bypass, full-with-return, then drain.
        for (int k = 0; k < 4; k++)
            rows.push_back(mk(1, 30'('h500 + 4 * k), 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 30'('h500 + 4 * k), 0, 0, 0));
        rows.push_back(mk(1, 'h510,  0, 0, 0,      0, 0, 0,            1, 0, 0, 0, 'h510,  0, 0, 0));
        rows.push_back(mk(1, 'h510,  0, 1, 'h60,   0, 0, 0,            1, 0, 0, 1, 'h60,   0, 0, 0));
        rows.push_back(mk(1, 'h510,  0, 0, 0,      0, 1, 'hF7,         1, 0, 0, 0, 'h510,  1, 0, 0));
        rows.push_back(mk(1, 'h510,  0, 0, 0,      0, 0, 0,            0, 0, 1, 0, 'h510,  0, 0, 0));
        for (int k = 0; k < 4; k++)
            rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'('hC0 + k), 0, 0, 0, 0, 0, 1, 0, 0));
        rows.push_back(mk(0, 0,      0, 0, 0,      0, 0, 0,            0, 0, 0, 0, 0,      0, 0, 0));
        run_rows("full");

        // Unsolicited return sets the sticky error; reset clears it without a clock edge.
        rows.push_back(mk(0, 0,      0, 0, 0,      0, 1, 'hE1,         0, 0, 0, 0, 0,      0, 0, 0));
        rows.push_back(mk(0, 0,      0, 0, 0,      0, 0, 0,            0, 0, 0, 0, 0,      0, 0, 1));
        rows.push_back(mk(0, 0,      0, 0, 0,      0, 0, 0,            0, 0, 0, 0, 0,      0, 0, 1));
        run_rows("err");
        @(negedge clk);
        idle_inputs();
        #2 rst = 1'b0;
        #1;
        checkOutput("err.async_clear", err, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // A reset with a read outstanding forgets its tag, so the late return is an error.
        rows.push_back(mk(1, 'h600,  0, 0, 0,      0, 0, 0,            0, 0, 1, 0, 'h600,  0, 0, 0));
        run_rows("rstmid");
        @(negedge clk);
        idle_inputs();
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        rows.push_back(mk(0, 0,      0, 0, 0,      0, 1, 'h66,         0, 0, 0, 0, 0,      0, 0, 0));
        rows.push_back(mk(0, 0,      0, 0, 0,      0, 0, 0,            0, 0, 0, 0, 0,      0, 0, 1));
        run_rows("rstmid");

        do_reset();
        run_random(2000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one external memory port between the instruction fetch port (imem) and the data port (dmem) of the core.
- Sits between the core's I and M stages and the memory controller.
- Adds no request latency: grant is combinational, and read responses are routed back by an in-order source-tag FIFO.
- dmem has priority; a streak counter guarantees fetch forward progress.

Parameters:
- MAX_OUTSTANDING, 4, depth of the read tag FIFO (power of 2, 2..16).
- MAX_STREAK, 3, consecutive dmem grants allowed while imem is waiting before imem is forced a grant (1..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_addr  in  30  word address of fetch.
- imem_rd  in  1  fetch read request; held stable until imem_wait is low.
- imem_wait  out  1  request not accepted this cycle.
- imem_rddata  out  32  fetch read data, valid when imem_rvalid.
- imem_rvalid  out  1  one-cycle pulse per returned fetch read.
- dmem_addr  in  30  word address.
- dmem_rd  in  1  data read request.
- dmem_wr  in  1  data write request; never asserted together with dmem_rd.
- dmem_wrdata  in  32  write data.
- dmem_wrmask  in  4  byte enables.
- dmem_wait  out  1  request not accepted this cycle.
- dmem_rddata  out  32  data read data.
- dmem_rvalid  out  1  one-cycle pulse per returned data read.
- mem_addr  out  30, mem_rd out 1, mem_wr out 1, mem_wrdata out 32, mem_wrmask out 4: selected request.
- mem_wait  in  1  memory cannot accept the presented request.
- mem_rddata  in  32, mem_rvalid in 1: in-order read return, any latency ≥1.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (rst low, async): FIFO empty (count 0, pointers 0), streak 0, lock clear, err 0. imem_rvalid and dmem_rvalid are 0. Waits follow combinational rules with empty state.
- Selection, in priority order:
  (1) lock set → locked source;
  (2) imem_rd and streak == MAX_STREAK → imem;
  (3) dmem_rd|dmem_wr → dmem;
  (4) imem_rd → imem;
  (5) none.
- mem_* mirrors the selected source's fields. With no selection, mem_rd = mem_wr = 0 and the other fields are don't-care (drive 0).
- Block: the selected request is a read and the FIFO count == MAX_OUTSTANDING. While blocked, mem_rd is forced 0. Full blocks regardless of a same-cycle mem_rvalid. Writes are never blocked.
- Accept = selected request present & ~mem_wait & ~block.
  - Selected source's wait = ~accept.
  - Unselected source's wait = its request.
- Lock: set at clock edge when a request was presented to memory (mem_rd|mem_wr) and mem_wait = 1; records the source. Cleared on accept. This keeps mem_* stable across memory stalls. A blocked request does not set the lock.
- Streak:
  - dmem accept while imem_rd → streak+1 (saturating at MAX_STREAK).
  - imem accept, or imem_rd low → streak 0.
- Tag FIFO:
  - Push the source bit (0 = imem, 1 = dmem) on an accepted read.
  - Pop on mem_rvalid. Push and pop may occur in the same cycle; the count is unchanged.
- Return: mem_rvalid routes mem_rddata to the popped tag's port. The matching rvalid is combinational in the same cycle; the other port's rvalid is 0. rddata is driven to both ports unconditionally.
- mem_rvalid with FIFO empty: no pop, both rvalid 0, err set. err is cleared only by reset.
- Pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-transaction: all outstanding tags are discarded; later rvalids set err.

Test Plan:
- Both idle, then imem_rd=1 addr 0x100, mem_wait=0 → mem_rd=1, mem_addr=0x100, imem_wait=0 same cycle. mem_rvalid two cycles later with 0xDEADBEEF → imem_rvalid=1, imem_rddata=0xDEADBEEF, dmem_rvalid=0.
- imem_rd and dmem_wr held continuously, mem_wait=0, MAX_STREAK=3 → grant order D,D,D,I,D,D,D,I. imem_wait low exactly every 4th cycle.
- dmem_rd addr 0x20 with mem_wait=1 for 3 cycles, imem_rd raised in cycle 2 with streak forced → mem_addr stays 0x20 all 3 cycles (lock). Accepted on cycle 4, then imem granted.
- Issue 4 imem reads with no returns (MAX_OUTSTANDING=4) → 5th read has mem_rd=0, imem_wait=1. A dmem_wr is still accepted. After one mem_rvalid, the read is accepted next cycle.
- Interleave I,D,I reads, return 3 rvalids back-to-back with data 1,2,3 → imem_rvalid data 1, dmem_rvalid data 2, imem_rvalid data 3. FIFO empty, err=0.
- mem_rvalid with nothing outstanding → err=1 and remains 1. Both rvalid 0. Assert rst low → err=0 immediately (async).
